// File: rtl/regfile_2w2r_sb.sv
// regfile_2w2r_sb: two-write/two-read register file with optional zero register, write bypass and busy scoreboard
module regfile_2w2r_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic              rs_ready_o,
  output logic              rt_ready_o,
  input  logic              wa_en_i,
  input  logic [ADDR_W-1:0] wa_addr_i,
  input  logic [DATA_W-1:0] wa_data_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              rsv_en_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  output logic [ADDR_W:0]   busy_cnt_o,
  output logic              conflict_o
);
  localparam int N = 2**ADDR_W;
  logic [DATA_W-1:0] r_mem [N];
  logic [N-1:0]      r_busy, w_busy_nxt;
  logic [ADDR_W:0]   r_busy_cnt, w_cnt_nxt;
  logic              r_conflict;
  logic              w_wa, w_wb, w_rsv, w_byp;
  logic [ADDR_W-1:0] w_ra [2];
  logic [DATA_W-1:0] w_rd [2];
  logic              w_rdy [2];
  assign w_wa  = wa_en_i && !(ZERO_REG != 0 && wa_addr_i == '0);
  assign w_wb  = wb_en_i && !(wa_en_i && wb_addr_i == wa_addr_i) && !(ZERO_REG != 0 && wb_addr_i == '0);
  assign w_rsv = rsv_en_i && !(ZERO_REG != 0 && rsv_addr_i == '0);
  assign w_byp = BYPASS != 0 && !rst_i;
  // reserve is applied after the write clears so the newer producer keeps the entry busy
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wa) w_busy_nxt[wa_addr_i] = 1'b0;
    if (w_wb) w_busy_nxt[wb_addr_i] = 1'b0;
    if (w_rsv) w_busy_nxt[rsv_addr_i] = 1'b1;
    if (rst_i) w_busy_nxt = '0;
    w_cnt_nxt = '0;
    for (int i = 0; i < N; i++) w_cnt_nxt = w_cnt_nxt + (ADDR_W+1)'(w_busy_nxt[i]);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (w_wa) r_mem[wa_addr_i] <= wa_data_i;
      if (w_wb) r_mem[wb_addr_i] <= wb_data_i;
      r_conflict <= wa_en_i && wb_en_i && wa_addr_i == wb_addr_i;
    end
    r_busy     <= w_busy_nxt;
    r_busy_cnt <= w_cnt_nxt;
  end
  assign w_ra[0] = rs_addr_i;
  assign w_ra[1] = rt_addr_i;
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic w_zero, w_hit_a, w_hit_b;
    assign w_zero  = ZERO_REG != 0 && w_ra[p] == '0;
    assign w_hit_a = w_byp && wa_en_i && wa_addr_i == w_ra[p];
    assign w_hit_b = w_byp && wb_en_i && wb_addr_i == w_ra[p];
    always_comb begin
      w_rd[p]  = w_zero ? '0 : w_hit_a ? wa_data_i : w_hit_b ? wb_data_i : r_mem[w_ra[p]];
      w_rdy[p] = w_zero || w_hit_a || w_hit_b || !r_busy[w_ra[p]];
    end
  end
  assign rs_data_o  = w_rd[0];
  assign rt_data_o  = w_rd[1];
  assign rs_ready_o = w_rdy[0];
  assign rt_ready_o = w_rdy[1];
  assign busy_cnt_o = r_busy_cnt;
  assign conflict_o = r_conflict;
endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// tb_regfile_2w2r_sb: directed vector table plus reset corner sequence for regfile_2w2r_sb
module tb_regfile_2w2r_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, wa_addr, wb_addr, rsv_addr;
  logic [31:0] wa_data, wb_data;
  logic        wa_en, wb_en, rsv_en;
  logic [31:0] rs_data, rt_data, nb_rs_data, nb_rt_data;
  logic        rs_ready, rt_ready, nb_rs_ready, nb_rt_ready;
  logic [5:0]  busy_cnt, nb_busy_cnt;
  logic        conflict, nb_conflict;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  regfile_2w2r_sb dut (
    .clk_i(clk), .rst_i(rst), .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
    .rs_data_o(rs_data), .rt_data_o(rt_data), .rs_ready_o(rs_ready), .rt_ready_o(rt_ready),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .busy_cnt_o(busy_cnt), .conflict_o(conflict)
  );

  regfile_2w2r_sb #(.BYPASS(0)) dut_nb (
    .clk_i(clk), .rst_i(rst), .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
    .rs_data_o(nb_rs_data), .rt_data_o(nb_rt_data), .rs_ready_o(nb_rs_ready), .rt_ready_o(nb_rt_ready),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .busy_cnt_o(nb_busy_cnt), .conflict_o(nb_conflict)
  );

  typedef struct {
    logic [31:0] wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, rsv_en, rsv_addr, rs, rt;
    logic [31:0] e_rs, e_rt, e_rsr, e_rtr, e_cnt, e_conf, e_nb;
  } vec_t;
  vec_t tv [23];

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s vec %0d got %h want %h", name, idx, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    wa_en = v.wa_en[0]; wa_addr = 5'(v.wa_addr); wa_data = v.wa_data;
    wb_en = v.wb_en[0]; wb_addr = 5'(v.wb_addr); wb_data = v.wb_data;
    rsv_en = v.rsv_en[0]; rsv_addr = 5'(v.rsv_addr);
    rs_addr = 5'(v.rs); rt_addr = 5'(v.rt);
  endtask

  initial begin
    //        wa_en wa_a wa_d          wb_en wb_a wb_d  rsv ra rs rt  e_rs          e_rt          rsr rtr cnt cf nb_rs
    tv[0]  = '{0, 0, 0,            0, 0,  0,    0, 0, 7,  31, 0,            0,            1, 1, 0, 0, 0};
    tv[1]  = '{1, 5, 'hDEADBEEF,   0, 0,  0,    0, 0, 5,  5,  'hDEADBEEF,   'hDEADBEEF,   1, 1, 0, 0, 0};
    tv[2]  = '{0, 0, 0,            0, 0,  0,    0, 0, 5,  0,  'hDEADBEEF,   0,            1, 1, 0, 0, 'hDEADBEEF};
    tv[3]  = '{1, 9, 'h11,         1, 9,  'h22, 0, 0, 9,  10, 'h11,         0,            1, 1, 0, 0, 0};
    tv[4]  = '{0, 0, 0,            0, 0,  0,    0, 0, 9,  9,  'h11,         'h11,         1, 1, 0, 1, 'h11};
    tv[5]  = '{0, 0, 0,            1, 10, 'h33, 0, 0, 10, 9,  'h33,         'h11,         1, 1, 0, 0, 0};
    tv[6]  = '{0, 0, 0,            0, 0,  0,    0, 0, 10, 9,  'h33,         'h11,         1, 1, 0, 0, 'h33};
    tv[7]  = '{1, 0, 'hFFFFFFFF,   0, 0,  0,    1, 0, 0,  0,  0,            0,            1, 1, 0, 0, 0};
    tv[8]  = '{0, 0, 0,            0, 0,  0,    0, 0, 0,  0,  0,            0,            1, 1, 0, 0, 0};
    tv[9]  = '{0, 0, 0,            0, 0,  0,    1, 3, 3,  3,  0,            0,            1, 1, 0, 0, 0};
    tv[10] = '{0, 0, 0,            0, 0,  0,    0, 0, 3,  5,  0,            'hDEADBEEF,   0, 1, 1, 0, 0};
    tv[11] = '{0, 0, 0,            1, 3,  'h44, 0, 0, 3,  3,  'h44,         'h44,         1, 1, 1, 0, 0};
    tv[12] = '{0, 0, 0,            0, 0,  0,    0, 0, 3,  3,  'h44,         'h44,         1, 1, 0, 0, 'h44};
    tv[13] = '{1, 3, 'h55,         0, 0,  0,    1, 3, 3,  6,  'h55,         0,            1, 1, 0, 0, 'h44};
    tv[14] = '{0, 0, 0,            0, 0,  0,    0, 0, 3,  3,  'h55,         'h55,         0, 0, 1, 0, 'h55};
    tv[15] = '{0, 0, 0,            0, 0,  0,    1, 3, 3,  3,  'h55,         'h55,         0, 0, 1, 0, 'h55};
    tv[16] = '{0, 0, 0,            0, 0,  0,    0, 0, 3,  3,  'h55,         'h55,         0, 0, 1, 0, 'h55};
    tv[17] = '{0, 0, 0,            0, 0,  0,    1, 4, 4,  3,  0,            'h55,         1, 0, 1, 0, 0};
    tv[18] = '{1, 3, 'h66,         1, 4,  'h77, 0, 0, 3,  4,  'h66,         'h77,         1, 1, 2, 0, 'h55};
    tv[19] = '{0, 0, 0,            0, 0,  0,    0, 0, 3,  4,  'h66,         'h77,         1, 1, 0, 0, 'h66};
    tv[20] = '{0, 0, 0,            0, 0,  0,    1, 8, 8,  8,  0,            0,            1, 1, 0, 0, 0};
    tv[21] = '{1, 0, 1,            1, 0,  2,    0, 0, 8,  0,  0,            0,            0, 1, 1, 0, 0};
    tv[22] = '{0, 0, 0,            0, 0,  0,    0, 0, 0,  8,  0,            0,            1, 0, 1, 1, 0};
    rst = 1'b1;
    drive(tv[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 23; i++) begin
      drive(tv[i]);
      #1;
      check("rs_data", i, rs_data, tv[i].e_rs);
      check("rt_data", i, rt_data, tv[i].e_rt);
      check("rs_ready", i, 32'(rs_ready), tv[i].e_rsr);
      check("rt_ready", i, 32'(rt_ready), tv[i].e_rtr);
      check("busy_cnt", i, 32'(busy_cnt), tv[i].e_cnt);
      check("conflict", i, 32'(conflict), tv[i].e_conf);
      check("nobyp_rs_data", i, nb_rs_data, tv[i].e_nb);
      @(negedge clk);
    end
    // mid-operation reset: r8 still busy, add r1 and r2, then reset alongside a write to r1
    drive(tv[0]);
    rsv_en = 1'b1; rsv_addr = 5'd1;
    @(negedge clk);
    rsv_addr = 5'd2;
    @(negedge clk);
    rsv_en = 1'b0;
    #1;
    check("mid_busy_cnt", 100, 32'(busy_cnt), 32'd3);
    rst = 1'b1;
    wa_en = 1'b1; wa_addr = 5'd1; wa_data = 32'hAB;
    rs_addr = 5'd1; rt_addr = 5'd2;
    #1;
    check("rst_no_bypass_data", 101, rs_data, 32'd0);
    check("rst_no_bypass_ready", 101, 32'(rs_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0; wa_en = 1'b0;
    rs_addr = 5'd1; rt_addr = 5'd5;
    #1;
    check("post_rst_r1", 102, rs_data, 32'd0);
    check("post_rst_r1_ready", 102, 32'(rs_ready), 32'd1);
    check("post_rst_r5", 102, rt_data, 32'd0);
    check("post_rst_cnt", 102, 32'(busy_cnt), 32'd0);
    check("post_rst_conflict", 102, 32'(conflict), 32'd0);
    rt_addr = 5'd2;
    #1;
    check("post_rst_r2_ready", 103, 32'(rt_ready), 32'd1);
    @(negedge clk);
    check("post_rst_r1_kept", 104, rs_data, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_2w2r_sb.md
Name: regfile_2w2r_sb

Overview:
Parametrised register file for the pipelined CPU datapath, succeeding the single-write register file. It provides two combinational read ports (RS/RT) and two synchronous write ports (A = ALU/WB path, B = load/secondary path), plus optional hardwired zero register, optional same-cycle write-to-read bypass, and a per-entry busy scoreboard. The block sits in ID: it supplies operands and operand-ready flags to the hazard unit and receives write-backs from WB.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 reads 0, is never written and is never busy
BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = reads return array contents only

Ports:
clk_i  in  1  clock, all state updates on posedge
rst_i  in  1  synchronous active-high reset
rs_addr_i  in  ADDR_W  read port RS address
rt_addr_i  in  ADDR_W  read port RT address
rs_data_o  out  DATA_W  RS read data (combinational)
rt_data_o  out  DATA_W  RT read data (combinational)
rs_ready_o  out  1  RS operand valid (not busy, or bypassed)
rt_ready_o  out  1  RT operand valid
wa_en_i  in  1  write port A enable (higher priority)
wa_addr_i  in  ADDR_W  write port A address
wa_data_i  in  DATA_W  write port A data
wb_en_i  in  1  write port B enable
wb_addr_i  in  ADDR_W  write port B address
wb_data_i  in  DATA_W  write port B data
rsv_en_i  in  1  reserve: mark rsv_addr_i busy (issue of a producer)
rsv_addr_i  in  ADDR_W  entry to reserve
busy_cnt_o  out  ADDR_W+1  registered count of busy entries
conflict_o  out  1  registered one-cycle pulse: both write ports hit the same address in the previous cycle

Behaviour:
- Reset: on posedge with rst_i=1, all entries <= 0, all busy bits <= 0, busy_cnt_o <= 0, conflict_o <= 0. Writes/reserves in that cycle are ignored. While rst_i=1, bypass is suppressed (reads return the array). After the reset edge: data outputs are 0, ready outputs are 1. A reset mid-operation discards all pending reservations.
- Writes: on posedge, if wa_en_i, entry[wa_addr_i] <= wa_data_i; if wb_en_i and (!wa_en_i or wb_addr_i != wa_addr_i), entry[wb_addr_i] <= wb_data_i. Same address on both ports: A wins, B is dropped, conflict_o = 1 for exactly the next cycle.
- Zero register (ZERO_REG=1): writes/reserves to address 0 are ignored; reads of address 0 return 0 with ready=1 regardless of bypass. Conflict on address 0 is still flagged.
- Read (per port X in {rs, rt}), priority order: ZERO_REG and addr==0 -> 0; BYPASS and wa_en_i and wa_addr_i==addr -> wa_data_i; BYPASS and wb_en_i and wb_addr_i==addr -> wb_data_i; else entry[addr]. Zero read latency.
- Scoreboard: on posedge, a write on either effective port clears busy[addr]; rsv_en_i sets busy[rsv_addr_i]. Reserve and write on the same address in one cycle: busy ends set (the newer producer wins). A dropped port-B write does not clear busy.
- ready: X_ready_o = !busy[addr] OR (BYPASS and an enabled write port matches addr this cycle) OR (ZERO_REG and addr==0).
- busy_cnt_o: registered; next = popcount of next busy vector (0..2**ADDR_W). Reserving an already busy entry does not increment the count.
- No handshake stalls: every request is accepted in the cycle it is presented.

Test Plan:
- Reset then read: after rst_i pulse, read addr 7 and 31 -> data 0, ready 1, busy_cnt_o 0, conflict_o 0.
- Basic write/read: wa writes 0xDEADBEEF to r5; next cycle rs_addr=5 -> 0xDEADBEEF; in the write cycle (BYPASS=1), rt_addr=5 -> 0xDEADBEEF as well; with BYPASS=0 the write cycle returns the old value 0.
- Port conflict: wa (r9, 0x11) and wb (r9, 0x22) in the same cycle -> r9 = 0x11, conflict_o = 1 for one cycle only; in a separate cycle, wb alone to r10 (0x33) -> r10 = 0x33, no conflict.
- Zero register: wa writes 0xFFFFFFFF to r0 and rsv r0 -> rs_addr=0 reads 0, ready 1, busy_cnt_o unchanged.
- Scoreboard: rsv r3 -> rs_ready=0, busy_cnt_o=1; wb writes r3 = 0x44 -> same-cycle ready=1 with data 0x44 (bypass), next cycle busy_cnt_o=0; rsv r3 plus wa write r3 in the same cycle -> busy stays 1.
- Reset mid-op: reserve r1, r2 and then assert rst_i together with a wa write to r1 -> all entries 0, busy_cnt_o 0, write discarded.
